multi_zone_sprinkler_ctrl: RTL

//  Multi-zone garden irrigation controller; next generation of the single-zone moisture/water sprinkler block.

---
 rtl/multi_zone_sprinkler_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_zone_sprinkler_ctrl.sv
// Multi-zone irrigation controller.
// Raw sensor pins are synchronised and debounced. Zones are then watered one at
// a time in round-robin order. Each run ends on wet soil, an empty tank, a disable
// or a timeout, and every run is followed by a fixed soak period.
// Handshakes: none. All inputs are level-sampled, and fault_clr is a single-cycle
// pulse that takes effect on the edge where it is seen high.
module multi_zone_sprinkler_ctrl #(
  parameter int NUM_ZONES       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_ON_CYCLES   = 1000,
  parameter int SOAK_CYCLES     = 100,
  localparam int ZW             = $clog2(NUM_ZONES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_ZONES-1:0] dry,
  input  logic                 water_ok,
  input  logic                 fault_clr,
  output logic [NUM_ZONES-1:0] valve,
  output logic                 relay_n,
  output logic                 buzzer,
  output logic                 busy,
  output logic [ZW-1:0]        active_zone,
  output logic [NUM_ZONES-1:0] zone_fault,
  output logic [1:0]           dbg_state
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int ONW = $clog2(MAX_ON_CYCLES) + 1;
  localparam int SKW = $clog2(SOAK_CYCLES) + 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ONW-1:0] ON_LAST   = ONW'(MAX_ON_CYCLES - 1);
  localparam logic [SKW-1:0] SOAK_LAST = SKW'(SOAK_CYCLES - 1);
  localparam logic [ZW-1:0]  ZONE_LAST = ZW'(NUM_ZONES - 1);
  // The tank bit sits above the moisture bits. It idles at 1 (water present).
  localparam logic [NUM_ZONES:0] IN_RESET = {1'b1, {NUM_ZONES{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WATER = 2'd1,
    ST_SOAK  = 2'd2
  } state_t;

  logic [NUM_ZONES:0]   r_sync1;
  logic [NUM_ZONES:0]   r_sync2;
  logic [NUM_ZONES:0]   r_db;
  logic [DBW-1:0]       r_db_cnt [NUM_ZONES+1];

  state_t               r_state;
  logic [NUM_ZONES-1:0] r_valve;
  logic                 r_relay_n;
  logic                 r_buzzer;
  logic [ZW-1:0]        r_active_zone;
  logic [NUM_ZONES-1:0] r_zone_fault;
  logic [ZW-1:0]        r_rr;
  logic [ONW-1:0]       r_on_cnt;
  logic [SKW-1:0]       r_soak_cnt;

  state_t               w_state;
  logic [NUM_ZONES-1:0] w_valve;
  logic                 w_relay_n;
  logic [ZW-1:0]        w_active_zone;
  logic [NUM_ZONES-1:0] w_zone_fault;
  logic [NUM_ZONES-1:0] w_fault_set;
  logic [ZW-1:0]        w_rr;
  logic [ONW-1:0]       w_on_cnt;
  logic [SKW-1:0]       w_soak_cnt;
  logic                 w_exit;

  logic [NUM_ZONES-1:0] w_dry_db;
  logic                 w_water_db;
  logic [NUM_ZONES-1:0] w_eligible;
  logic                 w_found;
  logic [ZW-1:0]        w_pick;
  logic [ZW-1:0]        w_cand;
  logic [ZW-1:0]        w_rr_next;

  assign w_dry_db   = r_db[NUM_ZONES-1:0];
  assign w_water_db = r_db[NUM_ZONES];
  assign w_eligible = w_dry_db & ~r_zone_fault;
  assign w_rr_next  = (r_active_zone == ZONE_LAST) ? '0 : r_active_zone + 1'b1;

  // Two-flop synchroniser for all asynchronous sensor pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= IN_RESET;
      r_sync2 <= IN_RESET;
    end else begin
      r_sync1 <= {water_ok, dry};
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debouncer. The output flips only after DEBOUNCE_CYCLES consecutive differing edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db <= IN_RESET;
      for (int i = 0; i <= NUM_ZONES; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i <= NUM_ZONES; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Round-robin search: take the first eligible zone at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_ZONES; k++) begin
      w_cand = ZW'((int'(r_rr) + k) % NUM_ZONES);
      if (!w_found && w_eligible[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Next-state and next-output logic for the watering FSM.
  always_comb begin
    w_state       = r_state;
    w_valve       = r_valve;
    w_relay_n     = r_relay_n;
    w_active_zone = r_active_zone;
    w_rr          = r_rr;
    w_on_cnt      = r_on_cnt;
    w_soak_cnt    = r_soak_cnt;
    w_fault_set   = '0;
    w_exit        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && w_water_db && w_found) begin
          w_state       = ST_WATER;
          w_active_zone = w_pick;
          w_valve       = {{(NUM_ZONES-1){1'b0}}, 1'b1} << w_pick;
          w_relay_n     = 1'b0;
          w_on_cnt      = '0;
        end
      end
      ST_WATER: begin
        w_on_cnt = r_on_cnt + 1'b1;
        // Exit causes are checked in priority order. Only the timeout records a fault.
        if (!enable || !w_water_db) begin
          w_exit = 1'b1;
        end else if (!w_dry_db[r_active_zone]) begin
          w_exit = 1'b1;
        end else if (r_on_cnt == ON_LAST) begin
          w_exit = 1'b1;
          w_fault_set[r_active_zone] = 1'b1;
        end
        if (w_exit) begin
          w_state    = ST_SOAK;
          w_valve    = '0;
          w_relay_n  = 1'b1;
          w_rr       = w_rr_next;
          w_soak_cnt = '0;
        end
      end
      ST_SOAK: begin
        if (r_soak_cnt == SOAK_LAST) begin
          w_state = ST_IDLE;
        end else begin
          w_soak_cnt = r_soak_cnt + 1'b1;
        end
      end
      default: begin
        w_state   = ST_IDLE;
        w_valve   = '0;
        w_relay_n = 1'b1;
      end
    endcase
    // A timeout on the same edge as fault_clr still leaves its new fault bit set.
    w_zone_fault = (fault_clr ? '0 : r_zone_fault) | w_fault_set;
  end

  // State and output registers. All outputs change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_valve       <= '0;
      r_relay_n     <= 1'b1;
      r_buzzer      <= 1'b0;
      r_active_zone <= '0;
      r_zone_fault  <= '0;
      r_rr          <= '0;
      r_on_cnt      <= '0;
      r_soak_cnt    <= '0;
    end else begin
      r_state       <= w_state;
      r_valve       <= w_valve;
      r_relay_n     <= w_relay_n;
      r_buzzer      <= ~w_water_db;
      r_active_zone <= w_active_zone;
      r_zone_fault  <= w_zone_fault;
      r_rr          <= w_rr;
      r_on_cnt      <= w_on_cnt;
      r_soak_cnt    <= w_soak_cnt;
    end
  end

  assign valve       = r_valve;
  assign relay_n     = r_relay_n;
  assign buzzer      = r_buzzer;
  assign busy        = (r_state != ST_IDLE);
  assign active_zone = r_active_zone;
  assign zone_fault  = r_zone_fault;
  assign dbg_state   = r_state;

endmodule
